secded_encoder: RTL and testbench

Streaming SECDED encoder: accepts 26-bit data words and emits 32-bit extended-Hamming codewords in the exact format consumed by the `ECC` corrector (32-bit in, corrected data out, `err_2_bit` flag). It is the write-side counterpart of `ECC` and sits in front of storage or link paths whose read side is `ECC`. The data path is a two-stage valid/ready pipeline with full throughput and backpressure support.

---
 rtl/secded_pkg.sv | 27 ++
 rtl/secded_parity.sv | 34 +++
 rtl/secded_encoder.sv | 112 +++++++++++
 tb/tb_secded_encoder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/secded_pkg.sv
// rtl/secded_pkg.sv - shared constants for the SECDED encoder
//
// Holds the fixed widths, the data-index to codeword-position map, the
// Hamming parity positions and, for each parity bit, the set of codeword
// positions it covers. Position p of the codeword lives at out_code[p].
// Position 0 holds the overall parity.

package secded_pkg;

  localparam int DATA_W = 26;
  localparam int CODE_W = 32;
  localparam int NPAR   = 5;

  // Data bits fill the non-power-of-two positions in ascending order.
  localparam int DATA_POS [DATA_W] = '{
     3,  5,  6,  7,  9, 10, 11, 12, 13, 14, 15, 17, 18,
    19, 20, 21, 22, 23, 24, 25, 26, 27, 28, 29, 30, 31
  };

  localparam int PARITY_POS [NPAR] = '{1, 2, 4, 8, 16};

  // Bit p is set when position p has bit k of its index set.
  localparam logic [CODE_W-1:0] PARITY_COVER [NPAR] = '{
    32'hAAAA_AAAA, 32'hCCCC_CCCC, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFFF_0000
  };

endpackage

// File: rtl/secded_parity.sv
// rtl/secded_parity.sv - combinational Hamming word builder
//
// Scatters the 26 data bits into codeword positions 1..31 and fills the
// five parity positions so every parity group has even parity.
//
// Ports:
//   data  in   DATA_W     data word
//   ham   out  [31:1]     Hamming word, bit p = codeword position p

module secded_parity
  import secded_pkg::*;
(
  input  logic [DATA_W-1:0]   data,
  output logic [CODE_W-1:1]   ham
);

  // data_word carries only data bits (parity positions zero), par_word only
  // parity bits; the two are disjoint so OR-ing them forms the Hamming word.
  logic [CODE_W-1:1] data_word;
  logic [CODE_W-1:1] par_word;

  for (genvar i = 0; i < DATA_W; i++) begin : g_data
    assign data_word[DATA_POS[i]] = data[i];
    assign par_word[DATA_POS[i]]  = 1'b0;
  end

  for (genvar k = 0; k < NPAR; k++) begin : g_par
    assign data_word[PARITY_POS[k]] = 1'b0;
    assign par_word[PARITY_POS[k]]  = ^(data_word & PARITY_COVER[k][CODE_W-1:1]);
  end

  assign ham = data_word | par_word;

endmodule

// File: rtl/secded_encoder.sv
// rtl/secded_encoder.sv - two-stage streaming SECDED (extended Hamming) encoder
//
// Stage 1 registers the Hamming word (positions 1..31); stage 2 adds the
// overall parity at position 0 and holds the output codeword. Ready is a
// combinational chain back from the output with no skid buffer.
//
// Optional feature macro: SECDED_ERR_INJ_EN (adds error-injection ports).
//
// Ports:
//   clk          in   1       clock, rising edge
//   rst          in   1       synchronous active-high reset
//   in_valid     in   1       in_data valid
//   in_ready     out  1       encoder accepts a word this cycle
//   in_data      in   26      data word
//   out_valid    out  1       out_code valid
//   out_ready    in   1       downstream accepts codeword
//   out_code     out  32      codeword
//   word_count   out  CNT_W   codewords emitted since reset (wraps)
//   inj_arm      in   1       (SECDED_ERR_INJ_EN) latch inj_mask, arm injection
//   inj_mask     in   32      (SECDED_ERR_INJ_EN) codeword bits to flip
//   inj_pending  out  1       (SECDED_ERR_INJ_EN) injection armed, not yet applied

module secded_encoder
  import secded_pkg::*;
#(
  parameter int CNT_W = 16
)
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CODE_W-1:0]  out_code,
  output logic [CNT_W-1:0]   word_count
`ifdef SECDED_ERR_INJ_EN
  ,
  input  logic               inj_arm,
  input  logic [CODE_W-1:0]  inj_mask,
  output logic               inj_pending
`endif
);

  logic              s1_valid;
  logic [CODE_W-1:1] s1_ham;
  logic [CODE_W-1:1] ham_next;
  logic              s2_load;
  logic              s1_adv;
  logic [CODE_W-1:0] flip;

  secded_parity u_parity (
    .data (in_data),
    .ham  (ham_next)
  );

  assign s2_load  = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_load;
  assign in_ready = !rst && s1_adv;

`ifdef SECDED_ERR_INJ_EN
  logic [CODE_W-1:0] inj_mask_q;

  assign flip = inj_pending ? inj_mask_q : '0;

  // A fresh arm wins over the clear so an arm on the consuming edge stays armed.
  always_ff @(posedge clk) begin
    if (rst) begin
      inj_pending <= 1'b0;
      inj_mask_q  <= '0;
    end else begin
      if (s2_load && s1_valid) begin
        inj_pending <= 1'b0;
      end
      if (inj_arm) begin
        inj_pending <= 1'b1;
        inj_mask_q  <= inj_mask;
      end
    end
  end
`else
  assign flip = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_ham     <= '0;
      out_valid  <= 1'b0;
      out_code   <= '0;
      word_count <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_ham <= ham_next;
        end
      end
      if (s2_load) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_code <= {s1_ham, ^s1_ham} ^ flip;
        end
      end
      if (out_valid && out_ready) begin
        word_count <= word_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_secded_encoder.sv
// tb/tb_secded_encoder.sv - self-checking bench for secded_encoder

module tb_secded_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [25:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_code;
  logic [15:0] word_count;
`ifdef SECDED_ERR_INJ_EN
  logic        inj_arm = 1'b0;
  logic [31:0] inj_mask = '0;
  logic        inj_pending;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  secded_encoder #(.CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_code   (out_code),
    .word_count (word_count)
`ifdef SECDED_ERR_INJ_EN
    ,
    .inj_arm    (inj_arm),
    .inj_mask   (inj_mask),
    .inj_pending(inj_pending)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference encoder: parity bits chosen so the XOR of set positions is zero.
  function automatic logic [31:0] model_enc(input logic [25:0] d_in);
    logic [31:0] c;
    logic [4:0]  syn;
    logic [25:0] d;
    c = '0; syn = '0; d = d_in;
    for (int p = 1; p < 32; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (d[0]) begin
          c   = c | (32'd1 << p);
          syn = syn ^ p[4:0];
        end
        d = d >> 1;
      end
    end
    for (int k = 0; k < 5; k++)
      if (((syn >> k) & 5'd1) != 0) c = c | (32'd1 << (1 << k));
    c[0] = ^c[31:1];
    return c;
  endfunction

  // Reference corrector-side view: {err_2_bit, syndrome_nonzero, data}.
  function automatic logic [27:0] model_dec(input logic [31:0] c);
    logic [4:0]  syn;
    logic [25:0] d;
    int          idx;
    syn = '0; d = '0; idx = 0;
    for (int p = 1; p < 32; p++) begin
      if (((c >> p) & 32'd1) != 0) syn = syn ^ p[4:0];
      if ((p & (p - 1)) != 0) begin
        if (((c >> p) & 32'd1) != 0) d = d | (26'd1 << idx);
        idx++;
      end
    end
    return {(syn != 0) && !(^c), syn != 0, d};
  endfunction

  // Send one word with out_ready=1, wait for it, report edges of latency.
  task automatic send_one(input logic [25:0] d, output logic [31:0] code, output int lat);
    @(negedge clk);
    in_valid = 1'b1; in_data = d; out_ready = 1'b1;
    #1 chk("in_ready_on_send", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    code = out_code;
    if (!out_valid) chk("out_valid_timeout", 64'd0, 64'd1);
  endtask

  typedef struct {
    logic [25:0] data;
    logic [31:0] code;
  } vec_t;

  initial begin
    vec_t        vecs [7];
    logic [31:0] code;
    logic [31:0] held;
    logic [27:0] dec;
    logic [25:0] exp_q [$];
    logic [25:0] cur;
    logic [25:0] wd;
    int          lat, sent, got, cyc;

    vecs[0] = '{26'h0000000, 32'h0000_0000};
    vecs[1] = '{26'h0000001, 32'h0000_000F};
    vecs[2] = '{26'h3FFFFFF, 32'hFFFF_FFFF};
    vecs[3] = '{26'h0000002, 32'h0000_0033};
    vecs[4] = '{26'h0000004, 32'h0000_0055};
    vecs[5] = '{26'h0000010, 32'h0000_0303};
    vecs[6] = '{26'h2000000, 32'h8001_0116};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_code", {32'd0, out_code}, 64'd0);
    chk("rst_word_count", {48'd0, word_count}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("in_ready_after_rst", {63'd0, in_ready}, 64'd1);

    // Directed table
    for (int i = 0; i < 7; i++) begin
      send_one(vecs[i].data, code, lat);
      chk("latency", 64'(lat), 64'd2);
      chk("table_code", {32'd0, code}, {32'd0, vecs[i].code});
      if (i == 0) begin
        @(negedge clk);
        chk("count_after_first", {48'd0, word_count}, 64'd1);
      end
    end
    @(negedge clk);
    chk("count_after_table", {48'd0, word_count}, 64'd7);

    // Reset, then stream 1000 words with a 5-cycle stall
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sent = 0; got = 0; cyc = 0; held = '0;
    cur = 26'($urandom);
    while (got < 1000 && cyc < 3000) begin
      @(negedge clk);
      out_ready = !(cyc >= 400 && cyc < 405);
      in_valid  = (sent < 1000);
      in_data   = cur;
      #1;
      if (cyc == 400) held = out_code;
      if (cyc > 400 && cyc < 405) begin
        chk("stall_out_stable", {32'd0, out_code}, {32'd0, held});
        chk("stall_in_ready_low", {63'd0, in_ready}, 64'd0);
        chk("stall_buffered", 64'(exp_q.size()), 64'd2);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("stream_unexpected_output", 64'd1, 64'd0);
        end else begin
          wd  = exp_q.pop_front();
          dec = model_dec(out_code);
          chk("stream_code", {32'd0, out_code}, {32'd0, model_enc(wd)});
          chk("stream_decode", {36'd0, dec}, {38'd0, wd});
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(cur);
        sent++;
        cur = 26'($urandom);
      end
      cyc++;
    end
    chk("stream_cycles", 64'(cyc), 64'd1007);
    @(negedge clk);
    in_valid = 1'b0;
    chk("stream_word_count", {48'd0, word_count}, 64'd1000);

    // Backpressure from empty: two words buffered, then in_ready drops
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_data = 26'h0ABCDEF;
    #1 chk("bp_ready_0", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    in_data = 26'h1234567;
    #1 chk("bp_ready_1", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    in_data = 26'h3333333;
    #1;
    chk("bp_ready_full", {63'd0, in_ready}, 64'd0);
    chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
    chk("bp_out_code", {32'd0, out_code}, {32'd0, model_enc(26'h0ABCDEF)});

    // Reset with two words buffered
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    #1 chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    #1;
    chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_word_count", {48'd0, word_count}, 64'd0);
    send_one(26'h155AA55, code, lat);
    chk("post_rst_code", {32'd0, code}, {32'd0, model_enc(26'h155AA55)});
    @(negedge clk);
    chk("post_rst_count", {48'd0, word_count}, 64'd1);

`ifdef SECDED_ERR_INJ_EN
    @(negedge clk);
    inj_arm = 1'b1; inj_mask = 32'h0000_0010;
    @(negedge clk);
    inj_arm = 1'b0;
    #1 chk("inj_pending_set", {63'd0, inj_pending}, 64'd1);
    send_one(26'h0000001, code, lat);
    chk("inj_code", {32'd0, code}, 64'h1F);
    chk("inj_pending_clear", {63'd0, inj_pending}, 64'd0);
    @(negedge clk);
    inj_arm = 1'b1; inj_mask = 32'h0000_0006;
    @(negedge clk);
    inj_arm = 1'b0;
    send_one(26'h2C0FFEE, code, lat);
    dec = model_dec(code);
    chk("inj_err_2_bit", {63'd0, dec[27]}, 64'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
